// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel divider, h/v counters, sync/blank decode and frame strobe.
// Define VGA_SYNC_PIPE_EN to register hsync/vsync/video_on one pixel behind the counters.
module vga_timing_gen #(
   parameter int unsigned CLK_DIV  = 4,
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter bit          SYNC_POL = 1'b0
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   output logic       pix_tick_o,
   output logic [9:0] h_cnt_o,
   output logic [9:0] v_cnt_o,
   output logic       hsync_o,
   output logic       vsync_o,
   output logic       video_on_o,
   output logic       frame_o
);

   localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
   localparam logic [9:0] V_ACT_M1 = 10'(V_ACTIVE - 1);
   localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [DIV_W-1:0] div_q, div_d;
   logic [9:0]       h_cnt_q, h_cnt_d;
   logic [9:0]       v_cnt_q, v_cnt_d;
   logic             frame_q, frame_d;
   logic             pix_tick, h_wrap;
   logic             hs_dec, vs_dec, vid_dec;

   always_comb begin
      pix_tick = (div_q == DIV_LAST);
      div_d    = pix_tick ? '0 : div_q + 1'b1;
      h_wrap   = (h_cnt_q == H_LAST);
      h_cnt_d  = h_cnt_q;
      v_cnt_d  = v_cnt_q;
      if (pix_tick) begin
         if (h_wrap) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
         end else begin
            h_cnt_d = h_cnt_q + 1'b1;
         end
      end
      // Strobe on the edge that loads (0, V_ACTIVE): first blanking line begins
      frame_d = pix_tick & h_wrap & (v_cnt_q == V_ACT_M1);
   end

   always_comb begin
      hs_dec  = ((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
      vs_dec  = ((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
      vid_dec = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         div_q   <= '0;
         h_cnt_q <= '0;
         v_cnt_q <= '0;
         frame_q <= 1'b0;
      end else begin
         div_q   <= div_d;
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
         frame_q <= frame_d;
      end
   end

`ifdef VGA_SYNC_PIPE_EN
   logic hsync_q, vsync_q, video_on_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         hsync_q    <= ~SYNC_POL;
         vsync_q    <= ~SYNC_POL;
         video_on_q <= 1'b0;
      end else if (pix_tick) begin
         hsync_q    <= hs_dec;
         vsync_q    <= vs_dec;
         video_on_q <= vid_dec;
      end
   end

   assign hsync_o    = hsync_q;
   assign vsync_o    = vsync_q;
   assign video_on_o = video_on_q;
`else
   assign hsync_o    = hs_dec;
   assign vsync_o    = vs_dec;
   assign video_on_o = vid_dec;
`endif

   assign pix_tick_o = pix_tick;
   assign h_cnt_o    = h_cnt_q;
   assign v_cnt_o    = v_cnt_q;
   assign frame_o    = frame_q;

endmodule
